// File: rtl/usb_ep_capture.sv
// usb_ep_capture: per-endpoint sliding capture window for the USB device core.
// Keeps the last DEPTH bytes seen on each endpoint and a saturating valid-byte
// count. Exposes a registered debug read port and a two-stage pattern matcher
// (default pattern: GET_DESCRIPTOR(Device) SETUP on EP0).
// Optional feature: define EP_STATS_EN to build per-endpoint 16-bit
// successful-transaction counters behind rd_pkt_cnt; otherwise it reads zero.
`timescale 1ns/1ps
module usb_ep_capture #(
    parameter int                 NUM_EP        = 16,
    parameter int                 DEPTH         = 8,
    parameter int                 MATCH_EP      = 0,
    parameter logic [8*DEPTH-1:0] MATCH_PATTERN = 64'h8006000100004000,
    parameter bit                 MATCH_SETUP   = 1'b1
) (
    input  logic        clk48,
    input  logic        rst,
    input  logic        usb_rst,
    input  logic        transaction_active,
    input  logic [3:0]  endpoint,
    input  logic        setup,
    input  logic        success,
    input  logic        data_strobe,
    input  logic [7:0]  din,
    input  logic [3:0]  rd_ep,
    input  logic [3:0]  rd_idx,
    output logic [7:0]  rd_data,
    output logic [4:0]  rd_cnt,
    output logic        match_stb,
    output logic        match_flag,
    input  logic        match_clr,
    output logic [15:0] rd_pkt_cnt
);

    localparam logic [4:0] DEPTH_L  = 5'(DEPTH);
    localparam logic [4:0] NUM_EP_L = 5'(NUM_EP);

    // Window byte [e][0] is the newest byte of endpoint e, [e][DEPTH-1] the oldest.
    logic [7:0]         win [NUM_EP][DEPTH];
    logic [4:0]         cnt [NUM_EP];
    logic               ta_p1;
    logic               ta_rise;
    logic               vld_p1;
    logic [3:0]         ep_p1;
    logic               setup_p1;
    logic [8*DEPTH-1:0] match_win;
    logic               match_hit;
    logic               rd_ok;
    logic [7:0]         rd_byte_sel;
    logic [4:0]         rd_cnt_sel;

    assign ta_rise = transaction_active & ~ta_p1;

    // Previous transaction_active, used only to find the start of a transaction.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) ta_p1 <= 1'b0;
        else     ta_p1 <= transaction_active;
    end

    // Shift each strobed byte into its endpoint window and track the valid count.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_EP; e++) begin
                cnt[e] <= '0;
                for (int i = 0; i < DEPTH; i++) win[e][i] <= '0;
            end
        end else if (usb_rst) begin
            for (int e = 0; e < NUM_EP; e++) begin
                cnt[e] <= '0;
                for (int i = 0; i < DEPTH; i++) win[e][i] <= '0;
            end
        end else begin
            for (int e = 0; e < NUM_EP; e++) begin
                if (endpoint == 4'(e)) begin
                    if (data_strobe) begin
                        win[e][0] <= din;
                        for (int i = 1; i < DEPTH; i++) win[e][i] <= win[e][i-1];
                    end
                    if (ta_rise)
                        cnt[e] <= data_strobe ? 5'd1 : 5'd0;
                    else if (data_strobe && cnt[e] != DEPTH_L)
                        cnt[e] <= cnt[e] + 5'd1;
                end
            end
        end
    end

    // Flatten the matched endpoint's window with the oldest byte in the MSBs.
    always_comb begin
        match_win = '0;
        for (int i = 0; i < DEPTH; i++) match_win[8*i +: 8] = win[MATCH_EP][i];
    end

    assign match_hit = vld_p1 && (ep_p1 == 4'(MATCH_EP)) && (cnt[MATCH_EP] == DEPTH_L) &&
                       (match_win == MATCH_PATTERN) && (setup_p1 || !MATCH_SETUP);

    // ---- stage p1: success context captured; window now includes any coincident byte
    always_ff @(posedge clk48) begin
        ep_p1    <= endpoint;
        setup_p1 <= setup;
    end

    // ---- stage p2: compare result registered; sticky flag follows the strobe
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            match_stb  <= 1'b0;
            match_flag <= 1'b0;
        end else if (usb_rst) begin
            vld_p1     <= 1'b0;
            match_stb  <= 1'b0;
            match_flag <= 1'b0;
        end else begin
            vld_p1     <= success;
            match_stb  <= match_hit;
            match_flag <= match_stb | (match_flag & ~match_clr);
        end
    end

    assign rd_ok = ({1'b0, rd_ep} < NUM_EP_L) && ({1'b0, rd_idx} < DEPTH_L);

    // Read-port select implemented as a compare mux so any index width is safe.
    always_comb begin
        rd_byte_sel = '0;
        rd_cnt_sel  = '0;
        for (int e = 0; e < NUM_EP; e++) begin
            if (rd_ep == 4'(e)) begin
                rd_cnt_sel = cnt[e];
                for (int i = 0; i < DEPTH; i++)
                    if (rd_idx == 4'(i)) rd_byte_sel = win[e][i];
            end
        end
    end

    // Registered read port; out-of-range selects return zero.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_cnt  <= '0;
        end else if (usb_rst) begin
            rd_data <= '0;
            rd_cnt  <= '0;
        end else begin
            rd_data <= rd_ok ? rd_byte_sel : 8'h00;
            rd_cnt  <= rd_ok ? rd_cnt_sel  : 5'd0;
        end
    end

`ifdef EP_STATS_EN
    logic [15:0] pkt_cnt [NUM_EP];
    logic [15:0] rd_pkt_sel;

    // Count successful transactions per endpoint; wraps naturally at 16 bits.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_EP; e++) pkt_cnt[e] <= '0;
        end else if (usb_rst) begin
            for (int e = 0; e < NUM_EP; e++) pkt_cnt[e] <= '0;
        end else begin
            for (int e = 0; e < NUM_EP; e++)
                if (success && endpoint == 4'(e)) pkt_cnt[e] <= pkt_cnt[e] + 16'd1;
        end
    end

    // Select the counter of the endpoint being read.
    always_comb begin
        rd_pkt_sel = '0;
        for (int e = 0; e < NUM_EP; e++)
            if (rd_ep == 4'(e)) rd_pkt_sel = pkt_cnt[e];
    end

    // Registered to line up with rd_data/rd_cnt.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst)          rd_pkt_cnt <= '0;
        else if (usb_rst) rd_pkt_cnt <= '0;
        else              rd_pkt_cnt <= rd_pkt_sel;
    end
`else
    assign rd_pkt_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_usb_ep_capture.sv
// Scoreboard bench for usb_ep_capture: the stimulus process updates a
// queue-based reference model and schedules expected outputs; a monitor on
// the falling edge compares whatever is due in each cycle.
`timescale 1ns/1ps
module tb_usb_ep_capture;

    logic        clk48 = 1'b0;
    logic        rst, usb_rst, transaction_active, setup, success, data_strobe, match_clr;
    logic [3:0]  endpoint, rd_ep, rd_idx;
    logic [7:0]  din, rd_data;
    logic [4:0]  rd_cnt;
    logic        match_stb, match_flag;
    logic [15:0] rd_pkt_cnt;

    usb_ep_capture dut (
        .clk48(clk48), .rst(rst), .usb_rst(usb_rst),
        .transaction_active(transaction_active), .endpoint(endpoint), .setup(setup),
        .success(success), .data_strobe(data_strobe), .din(din),
        .rd_ep(rd_ep), .rd_idx(rd_idx), .rd_data(rd_data), .rd_cnt(rd_cnt),
        .match_stb(match_stb), .match_flag(match_flag), .match_clr(match_clr),
        .rd_pkt_cnt(rd_pkt_cnt)
    );

    always #10 clk48 = ~clk48;

    int cyc = 0;
    always @(posedge clk48) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: byte history per endpoint, newest at the front.
    logic [7:0] mwin [16][$];
    int         mcnt [16];
    int         m_pkt [16];
    bit         m_flag;
    bit         m_ta_prev;
    bit         exp_stb [int];
    logic [7:0] pat [8] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    logic [7:0] buf_b [16];

    typedef struct { int due; int sel; int exp; } chk_t;
    chk_t chk_q [$];

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void push_chk(int due, int sel, int exp);
        chk_t c;
        c.due = due; c.sel = sel; c.exp = exp;
        chk_q.push_back(c);
    endfunction

    // Monitor: compare match pulses and every scheduled output due this cycle.
    always @(negedge clk48) begin
        bit e;
        e = exp_stb.exists(cyc);
        if (match_stb || e) chk("match_stb", int'(match_stb), int'(e));
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].due == cyc) begin
                case (chk_q[i].sel)
                    0:       chk("rd_data", int'(rd_data), chk_q[i].exp);
                    1:       chk("rd_cnt", int'(rd_cnt), chk_q[i].exp);
                    2:       chk("rd_pkt_cnt", int'(rd_pkt_cnt), chk_q[i].exp);
                    default: chk("match_flag", int'(match_flag), chk_q[i].exp);
                endcase
                chk_q.delete(i);
            end
        end
    end

    // One clock of stimulus: drive inputs, schedule expectations, advance model.
    task automatic step(input bit ta, input int ep, input bit su, input bit sc,
                        input bit ds, input logic [7:0] d, input int rep, input int ridx,
                        input bit clr, input bit ur);
        int  ed, ec;
        bit  hit;
        transaction_active = ta; endpoint = 4'(ep); setup = su; success = sc;
        data_strobe = ds; din = d; rd_ep = 4'(rep); rd_idx = 4'(ridx);
        match_clr = clr; usb_rst = ur;
        // Reads see the state before this cycle's inputs take effect.
        if (ridx >= 8) begin
            ed = 0; ec = 0;
        end else begin
            ed = (ridx < mwin[rep].size()) ? int'(mwin[rep][ridx]) : 0;
            ec = mcnt[rep];
        end
        if (ur) begin ed = 0; ec = 0; end
        push_chk(cyc + 1, 0, ed);
        push_chk(cyc + 1, 1, ec);
`ifdef EP_STATS_EN
        push_chk(cyc + 1, 2, ur ? 0 : m_pkt[rep]);
`else
        push_chk(cyc + 1, 2, 0);
`endif
        if (ur) m_flag = 1'b0;
        else    m_flag = exp_stb.exists(cyc) ? 1'b1 : (m_flag && !clr);
        push_chk(cyc + 1, 3, int'(m_flag));
        if (ur) begin
            for (int e = 0; e < 16; e++) begin
                mwin[e].delete(); mcnt[e] = 0; m_pkt[e] = 0;
            end
            if (exp_stb.exists(cyc + 1)) exp_stb.delete(cyc + 1);
            if (exp_stb.exists(cyc + 2)) exp_stb.delete(cyc + 2);
        end else begin
            if (ta && !m_ta_prev) mcnt[ep] = 0;
            if (ds) begin
                mwin[ep].push_front(d);
                if (mwin[ep].size() > 8) void'(mwin[ep].pop_back());
                if (mcnt[ep] < 8) mcnt[ep]++;
            end
            if (sc) begin
                m_pkt[ep] = (m_pkt[ep] + 1) & 16'hFFFF;
                hit = (ep == 0) && (mcnt[0] == 8) && su;
                if (hit)
                    for (int j = 0; j < 8; j++)
                        if (mwin[0][j] != pat[7-j]) hit = 1'b0;
                if (hit) exp_stb[cyc + 2] = 1'b1;
            end
        end
        m_ta_prev = ta;
        @(negedge clk48);
    endtask

    // Same as step with a random read address, biased toward the active endpoint.
    task automatic rstep(input bit ta, input int ep, input bit su, input bit sc,
                         input bit ds, input logic [7:0] d, input bit clr, input bit ur);
        int rep;
        rep = ($urandom_range(0, 1) == 0) ? ep : int'($urandom_range(0, 15));
        step(ta, ep, su, sc, ds, d, rep, int'($urandom_range(0, 9)), clr, ur);
    endtask

    // scm: 0 no success, 1 success with last byte, 2 success one cycle after.
    task automatic send_txn(input int ep, input bit su, input int n, input int scm);
        for (int i = 0; i < n; i++)
            rstep(1'b1, ep, su, (scm == 1) && (i == n - 1), 1'b1, buf_b[i], 1'b0, 1'b0);
        if (scm == 2 || (n == 0 && scm != 0))
            rstep(1'b1, ep, su, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        rstep(1'b0, ep, su, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic load_pat();
        for (int i = 0; i < 8; i++) buf_b[i] = pat[i];
    endtask

    task automatic idle(input int n, input int rep, input int ridx);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, rep, ridx, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; usb_rst = 1'b0; transaction_active = 1'b0; endpoint = '0;
        setup = 1'b0; success = 1'b0; data_strobe = 1'b0; din = '0;
        rd_ep = '0; rd_idx = '0; match_clr = 1'b0;
        m_flag = 1'b0; m_ta_prev = 1'b0;
        for (int e = 0; e < 16; e++) begin mcnt[e] = 0; m_pkt[e] = 0; end
        repeat (3) @(negedge clk48);
        chk("reset rd_data", int'(rd_data), 0);
        chk("reset rd_cnt", int'(rd_cnt), 0);
        chk("reset match_stb", int'(match_stb), 0);
        chk("reset match_flag", int'(match_flag), 0);
        chk("reset rd_pkt_cnt", int'(rd_pkt_cnt), 0);
        rst = 1'b0;

        // GET_DESCRIPTOR setup on EP0 with success on the last byte.
        load_pat();
        send_txn(0, 1'b1, 8, 1);
        idle(3, 0, 7);
        idle(1, 0, 0);

        // Non-matching variants: wrong endpoint, not setup, only seven bytes counted.
        send_txn(1, 1'b1, 8, 1);
        send_txn(0, 1'b0, 8, 2);
        buf_b[0] = 8'h80;
        send_txn(0, 1'b1, 1, 0);
        for (int i = 0; i < 7; i++) buf_b[i] = pat[i+1];
        send_txn(0, 1'b1, 7, 1);
        idle(3, 0, 7);

        // Twelve bytes on EP2: oldest four dropped, count saturates.
        for (int i = 0; i < 12; i++) buf_b[i] = 8'(i + 1);
        send_txn(2, 1'b0, 12, 0);
        idle(1, 2, 0);
        idle(1, 2, 7);
        idle(1, 2, 8);

        // Interleaved EP3/EP4; a new EP3 transaction zeroes its count until a byte.
        for (int i = 0; i < 3; i++) buf_b[i] = 8'hA0 + 8'(i);
        send_txn(3, 1'b0, 3, 0);
        for (int i = 0; i < 2; i++) buf_b[i] = 8'hB0 + 8'(i);
        send_txn(4, 1'b0, 2, 0);
        step(1'b1, 3, 1'b0, 1'b0, 1'b0, 8'h00, 3, 0, 1'b0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b0, 1'b0, 8'h00, 3, 0, 1'b0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b0, 1'b1, 8'hC5, 4, 1, 1'b0, 1'b0);
        step(1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h00, 3, 1, 1'b0, 1'b0);
        idle(1, 3, 0);

        // Clear coincident with the match pulse, then clear again.
        load_pat();
        send_txn(0, 1'b1, 8, 1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1'b1, 1'b0);
        idle(2, 0, 0);

        // Bus reset mid-packet with a coincident byte.
        for (int i = 0; i < 4; i++) rstep(1'b1, 6, 1'b0, 1'b0, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 6, 1'b0, 1'b1, 1'b1, 8'h6F, 6, 0, 1'b0, 1'b1);
        step(1'b1, 6, 1'b0, 1'b0, 1'b0, 8'h00, 6, 0, 1'b0, 1'b0);
        step(1'b0, 6, 1'b0, 1'b0, 1'b0, 8'h00, 6, 0, 1'b0, 1'b0);

        // Three successful transactions on EP5.
        for (int k = 0; k < 3; k++) begin
            buf_b[0] = 8'h50 + 8'(k);
            send_txn(5, 1'b0, 1, 1 + (k % 2));
        end
        idle(1, 5, 0);

        // Randomized traffic, including occasional bus resets and flag clears.
        for (int t = 0; t < 250; t++) begin
            int ep, n;
            bit su;
            ep = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
            su = ($urandom_range(0, 1) == 1);
            if (ep == 0 && $urandom_range(0, 1) == 1) begin
                load_pat(); n = 8;
            end else begin
                n = int'($urandom_range(0, 12));
                for (int i = 0; i < n; i++) buf_b[i] = 8'($urandom);
            end
            send_txn(ep, su, n, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 24) == 0)
                rstep(1'b1, ep, su, 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0)
                rstep(1'b0, ep, su, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end

        idle(6, 0, 0);
        repeat (3) @(negedge clk48);
        chk("scoreboard drained", chk_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
